// File: rtl/mor1kx_tcm_loader.sv
// mor1kx_tcm_loader: boot-time copier from a wishbone source window into the ibus TCM.
// Holds the CPU in reset until every word has been written to the TCM populate port.
module mor1kx_tcm_loader #(
    parameter int          TCM_ADDR_WIDTH = 12,
    parameter int          WORD_COUNT     = 1024,
    parameter logic [31:0] SRC_BASE       = 32'hF0000000,
    parameter bit          AUTOSTART      = 1'b1,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        cpu_rst_o,
    output logic [31:0] src_adr_o,
    output logic        src_cyc_o,
    output logic        src_stb_o,
    output logic        src_we_o,
    output logic [3:0]  src_sel_o,
    output logic [2:0]  src_cti_o,
    output logic [1:0]  src_bte_o,
    input  logic [31:0] src_dat_i,
    input  logic        src_ack_i,
    input  logic        src_err_i,
    output logic [31:0] tcm_adr_o,
    output logic        tcm_cyc_o,
    output logic        tcm_stb_o,
    output logic        tcm_we_o,
    output logic [3:0]  tcm_sel_o,
    output logic [2:0]  tcm_cti_o,
    output logic [1:0]  tcm_bte_o,
    output logic [31:0] tcm_dat_o,
    input  logic        tcm_ack_i,
    input  logic        tcm_err_i
);
    localparam int CW = WORD_COUNT > 0 ? $clog2(WORD_COUNT + 1) : 1;
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST    = CW'(WORD_COUNT > 0 ? WORD_COUNT - 1 : 0);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] to_q;
    logic [31:0]   src_adr_q, dat_q;
    logic          auto_q, busy_q, done_q, err_q, cpu_rst_q, src_cyc_q, tcm_cyc_q;
    logic          to_hit;

    // The wait that would make the count reach TIMEOUT_CYCLES aborts instead.
    assign to_hit = (TIMEOUT_CYCLES > 0) && (to_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            to_q      <= '0;
            src_adr_q <= SRC_BASE;
            dat_q     <= '0;
            auto_q    <= AUTOSTART;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            src_cyc_q <= 1'b0;
            tcm_cyc_q <= 1'b0;
        end else begin
            case (state_q)
                RD: begin
                    if (src_err_i || (!src_ack_i && to_hit)) begin
                        state_q   <= ERR;
                        src_cyc_q <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                    end else if (src_ack_i) begin
                        state_q   <= WR;
                        dat_q     <= src_dat_i;
                        src_cyc_q <= 1'b0;
                        tcm_cyc_q <= 1'b1;
                        to_q      <= '0;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                WR: begin
                    if (tcm_err_i || (!tcm_ack_i && to_hit)) begin
                        state_q   <= ERR;
                        tcm_cyc_q <= 1'b0;
                        busy_q    <= 1'b0;
                        err_q     <= 1'b1;
                    end else if (tcm_ack_i) begin
                        tcm_cyc_q <= 1'b0;
                        if (cnt_q == LAST) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q   <= RD;
                            cnt_q     <= cnt_q + 1'b1;
                            src_adr_q <= src_adr_q + 32'd4;
                            src_cyc_q <= 1'b1;
                            to_q      <= '0;
                        end
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: begin
                    if (start_i || auto_q) begin
                        auto_q    <= 1'b0;
                        cnt_q     <= '0;
                        to_q      <= '0;
                        src_adr_q <= SRC_BASE;
                        err_q     <= 1'b0;
                        if (WORD_COUNT == 0) begin
                            state_q   <= DONE;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q   <= RD;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                            cpu_rst_q <= 1'b1;
                            src_cyc_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign cpu_rst_o = cpu_rst_q;
    assign src_adr_o = src_adr_q;
    assign src_cyc_o = src_cyc_q;
    assign src_stb_o = src_cyc_q;
    assign src_we_o  = 1'b0;
    assign src_sel_o = 4'hf;
    assign src_cti_o = 3'b000;
    assign src_bte_o = 2'b00;
    assign tcm_adr_o = {{(32 - TCM_ADDR_WIDTH){1'b0}}, TCM_ADDR_WIDTH'({cnt_q, 2'b00})};
    assign tcm_cyc_o = tcm_cyc_q;
    assign tcm_stb_o = tcm_cyc_q;
    assign tcm_we_o  = tcm_cyc_q;
    assign tcm_sel_o = 4'hf;
    assign tcm_cti_o = 3'b000;
    assign tcm_bte_o = 2'b00;
    assign tcm_dat_o = dat_q;
endmodule

// File: tb/tb_mor1kx_tcm_loader.sv
// tb_mor1kx_tcm_loader: bench for the TCM boot copier with registered-ack wishbone slave models.
module tb_mor1kx_tcm_loader;
    localparam int          WC   = 4;
    localparam int          TO   = 8;
    localparam int          TAW  = 8;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, start1 = 1'b0;
    always #5 clk = ~clk;

    logic        busy, done, err, cpu_rst, src_cyc, src_stb, src_we, tcm_cyc, tcm_stb, tcm_we;
    logic [31:0] src_adr, tcm_adr, tcm_dat, s_dat;
    logic [3:0]  src_sel, tcm_sel;
    logic [2:0]  src_cti, tcm_cti;
    logic [1:0]  src_bte, tcm_bte;
    logic        s_ack, s_err, t_ack, t_err;

    mor1kx_tcm_loader #(.TCM_ADDR_WIDTH(TAW), .WORD_COUNT(WC), .SRC_BASE(BASE),
                        .AUTOSTART(1'b1), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy), .done_o(done),
        .err_o(err), .cpu_rst_o(cpu_rst), .src_adr_o(src_adr), .src_cyc_o(src_cyc),
        .src_stb_o(src_stb), .src_we_o(src_we), .src_sel_o(src_sel), .src_cti_o(src_cti),
        .src_bte_o(src_bte), .src_dat_i(s_dat), .src_ack_i(s_ack), .src_err_i(s_err),
        .tcm_adr_o(tcm_adr), .tcm_cyc_o(tcm_cyc), .tcm_stb_o(tcm_stb), .tcm_we_o(tcm_we),
        .tcm_sel_o(tcm_sel), .tcm_cti_o(tcm_cti), .tcm_bte_o(tcm_bte), .tcm_dat_o(tcm_dat),
        .tcm_ack_i(t_ack), .tcm_err_i(t_err));

    logic        busy1, done1, err1, cpu_rst1, src_cyc1, src_stb1, src_we1, tcm_cyc1, tcm_stb1, tcm_we1;
    logic [31:0] src_adr1, tcm_adr1, tcm_dat1;
    logic [3:0]  src_sel1, tcm_sel1;
    logic [2:0]  src_cti1, tcm_cti1;
    logic [1:0]  src_bte1, tcm_bte1;

    mor1kx_tcm_loader #(.TCM_ADDR_WIDTH(TAW), .WORD_COUNT(0), .SRC_BASE(BASE),
                        .AUTOSTART(1'b0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .err_o(err1), .cpu_rst_o(cpu_rst1), .src_adr_o(src_adr1), .src_cyc_o(src_cyc1),
        .src_stb_o(src_stb1), .src_we_o(src_we1), .src_sel_o(src_sel1), .src_cti_o(src_cti1),
        .src_bte_o(src_bte1), .src_dat_i(32'h0), .src_ack_i(1'b0), .src_err_i(1'b0),
        .tcm_adr_o(tcm_adr1), .tcm_cyc_o(tcm_cyc1), .tcm_stb_o(tcm_stb1), .tcm_we_o(tcm_we1),
        .tcm_sel_o(tcm_sel1), .tcm_cti_o(tcm_cti1), .tcm_bte_o(tcm_bte1), .tcm_dat_o(tcm_dat1),
        .tcm_ack_i(1'b0), .tcm_err_i(1'b0));

    logic [31:0] rom [WC];
    logic [31:0] tmem [64];
    int src_wait = 0, err_word = -1, tcm_err_word = -1;
    bit src_mute = 1'b0;
    int s_w = 0, bad_src = 0, wr_cnt = 0, bad_tadr = 0, stb_cyc = 0, bus1 = 0;
    int total = 0, bad = 0;

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] d;
        d = (a - BASE) >> 2;
        return (d < 32'(WC)) ? int'(d) : WC;
    endfunction

    // Source ROM: ack/err one cycle after stb is seen plus src_wait extra cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            s_w   <= 0;
            s_dat <= '0;
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            if (!src_cyc) s_w <= 0;
            else if (src_stb && !s_ack && !s_err) begin
                if (!src_mute && s_w >= src_wait) begin
                    s_w <= 0;
                    if (idx_of(src_adr) >= WC || src_we) bad_src <= bad_src + 1;
                    else if (idx_of(src_adr) == err_word) s_err <= 1'b1;
                    else begin
                        s_ack <= 1'b1;
                        s_dat <= rom[idx_of(src_adr)];
                    end
                end else s_w <= s_w + 1;
            end
        end
    end

    // TCM populate port: registered ack, records every accepted write.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_ack <= 1'b0;
            t_err <= 1'b0;
        end else begin
            t_ack <= 1'b0;
            t_err <= 1'b0;
            if (tcm_cyc && tcm_stb && !t_ack && !t_err) begin
                if (!tcm_we || tcm_adr >= 32'(4 * WC) || tcm_adr[1:0] != 2'b00 || tcm_sel != 4'hf)
                    bad_tadr <= bad_tadr + 1;
                else if (int'(tcm_adr[7:2]) == tcm_err_word) t_err <= 1'b1;
                else begin
                    t_ack <= 1'b1;
                    wr_cnt <= wr_cnt + 1;
                    tmem[tcm_adr[7:2]] <= tcm_dat;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (src_stb) stb_cyc <= stb_cyc + 1;
        if (src_cyc1 || tcm_cyc1) bus1 <= bus1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!(done || err) && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic load_rom();
        foreach (rom[i]) rom[i] = $urandom;
    endtask

    task automatic chk_mem(input string tag, input int k);
        for (int i = 0; i < k; i++) chk($sformatf("%s_mem%0d", tag, i), tmem[i], rom[i]);
    endtask

    initial begin
        int n, b, s, w, k;
        load_rom();
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_src_cyc", 32'({src_cyc, src_stb, src_we}), 0);
        chk("rst_tcm_cyc", 32'({tcm_cyc, tcm_stb, tcm_we}), 0);
        chk("rst_tcm_adr", tcm_adr, 0);
        chk("rst_tcm_dat", tcm_dat, 0);
        chk("consts", {16'h0, src_sel, src_cti, src_bte, tcm_sel, tcm_cti}, {16'h0, 4'hf, 3'b0, 2'b0, 4'hf, 3'b0});

        // autostart copy, zero-wait source
        @(negedge clk);
        rst_n = 1'b1;
        b = wr_cnt;
        @(posedge clk);
        #1 wait_end(n);
        chk("auto_cycles", n, 4 * WC);
        chk("auto_done", 32'({done, err, busy, cpu_rst}), 32'b1000);
        chk("auto_writes", wr_cnt - b, WC);
        chk_mem("auto", WC);
        chk("idle_dut0_done", 32'({done1, cpu_rst1, busy1}), 32'b010);

        // wait states, with a start pulse during the copy that must be ignored
        w = $urandom_range(1, 3);
        src_wait = w;
        load_rom();
        s = stb_cyc;
        b = wr_cnt;
        go();
        fork
            begin
                repeat (5) @(negedge clk);
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
        join_none
        wait_end(n);
        chk("wait_cycles", n, WC * (4 + w));
        chk("wait_stb_cycles", stb_cyc - s, WC * (2 + w));
        chk("wait_writes", wr_cnt - b, WC);
        chk("wait_done", 32'({done, err, cpu_rst}), 32'b100);
        chk_mem("wait", WC);
        src_wait = 0;
        repeat (2) @(posedge clk);

        // source error part-way, then retry
        k = $urandom_range(1, WC - 1);
        err_word = k;
        load_rom();
        b = wr_cnt;
        #1 go();
        wait_end(n);
        chk("serr_cycles", n, 4 * k + 2);
        chk("serr_flags", 32'({done, err, busy, cpu_rst}), 32'b0101);
        chk("serr_buses", 32'({src_cyc, tcm_cyc}), 0);
        chk("serr_writes", wr_cnt - b, k);
        chk_mem("serr", k);
        err_word = -1;
        load_rom();
        b = wr_cnt;
        go();
        wait_end(n);
        chk("retry_cycles", n, 4 * WC);
        chk("retry_flags", 32'({done, err, cpu_rst}), 32'b100);
        chk("retry_writes", wr_cnt - b, WC);
        chk_mem("retry", WC);

        // TCM error
        k = $urandom_range(0, WC - 1);
        tcm_err_word = k;
        b = wr_cnt;
        go();
        wait_end(n);
        chk("terr_cycles", n, 4 * k + 4);
        chk("terr_flags", 32'({done, err, cpu_rst}), 32'b011);
        chk("terr_writes", wr_cnt - b, k);
        tcm_err_word = -1;

        // silent source: timeout
        src_mute = 1'b1;
        go();
        wait_end(n);
        chk("to_cycles", n, TO);
        chk("to_flags", 32'({err, src_cyc, src_stb, cpu_rst}), 32'b1001);
        src_mute = 1'b0;

        // reset mid-copy
        load_rom();
        go();
        repeat ($urandom_range(3, 12)) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_buses", 32'({src_cyc, src_stb, tcm_cyc, tcm_stb, tcm_we}), 0);
        chk("mrst_flags", 32'({busy, done, err, cpu_rst}), 32'b0001);
        chk("mrst_adr", tcm_adr, 0);
        load_rom();
        @(negedge clk);
        rst_n = 1'b1;
        b = wr_cnt;
        @(posedge clk);
        #1 wait_end(n);
        chk("mrst_cycles", n, 4 * WC);
        chk("mrst_writes", wr_cnt - b, WC);
        chk_mem("mrst", WC);

        // empty copy
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        chk("wc0_flags", 32'({done1, busy1, err1, cpu_rst1}), 32'b1000);
        repeat (2) @(posedge clk);
        #1 chk("wc0_no_bus", bus1, 0);

        chk("src_addr_ok", bad_src, 0);
        chk("tcm_addr_ok", bad_tadr, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
